// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready inter-stage pipeline register with stall, flush and a saturating bubble counter.
// Optional feature: define PIPE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
   parameter int unsigned       DATA_W     = 32,
   parameter int unsigned       CTRL_W     = 16,
   parameter logic [CTRL_W-1:0] FLUSH_CTRL = '0,
   parameter int unsigned       CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  bubble_cnt
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              in_xfer;
   logic              out_xfer;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
   logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

   assign out_xfer   = out_valid & out_ready & ~stall;
   assign out_data   = out_data_q;
   assign out_ctrl   = out_ctrl_q;
   assign bubble_cnt = bubble_cnt_q;

`ifdef PIPE_SKID_EN
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign in_xfer   = in_valid & in_ready_q;

   always_comb begin
      // NOTE: every output gets a hold default first so no path through the case infers a latch.
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_ctrl_d  = out_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) begin
         state_d     = ST_EMPTY;
         out_data_d  = '0;
         out_ctrl_d  = FLUSH_CTRL;
         skid_data_d = '0;
         skid_ctrl_d = FLUSH_CTRL;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  state_d    = ST_FULL;
                  out_data_d = in_data;
                  out_ctrl_d = in_ctrl;
               end
            end
            ST_FULL: begin
               if (in_xfer && out_xfer) begin
                  out_data_d = in_data;
                  out_ctrl_d = in_ctrl;
               end else if (in_xfer) begin
                  state_d     = ST_SKID;
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
               end else if (out_xfer) begin
                  state_d    = ST_EMPTY;
                  out_ctrl_d = FLUSH_CTRL;
               end
            end
            ST_SKID: begin
               // Older beat leaves first; the skid entry is promoted, never bypassed.
               if (out_xfer) begin
                  state_d    = ST_FULL;
                  out_data_d = skid_data_q;
                  out_ctrl_d = skid_ctrl_q;
               end
            end
            default: begin
               state_d    = ST_EMPTY;
               out_ctrl_d = FLUSH_CTRL;
            end
         endcase
      end
      in_ready_d = (state_d != ST_SKID);
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (!reset) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_data_q  <= '0;
         out_ctrl_q  <= FLUSH_CTRL;
         skid_data_q <= '0;
         skid_ctrl_q <= FLUSH_CTRL;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_data_q  <= out_data_d;
         out_ctrl_q  <= out_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
      end
   end
`else
   logic out_valid_q, out_valid_d;

   assign in_ready  = ~stall & (~out_valid_q | out_ready);
   assign out_valid = out_valid_q;
   assign in_xfer   = in_valid & in_ready;

   always_comb begin
      // NOTE: every output gets a hold default first so no path through the if-chain infers a latch.
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ctrl_d  = out_ctrl_q;
      // Stall needs no branch: in_xfer and out_xfer are both gated by ~stall, so it falls through to hold.
      if (flush) begin
         out_valid_d = 1'b0;
         out_data_d  = '0;
         out_ctrl_d  = FLUSH_CTRL;
      end else if (in_xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data;
         out_ctrl_d  = in_ctrl;
      end else if (out_xfer) begin
         out_valid_d = 1'b0;
         out_ctrl_d  = FLUSH_CTRL;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (!reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ctrl_q  <= FLUSH_CTRL;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ctrl_q  <= out_ctrl_d;
      end
   end
`endif

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (cnt_clr) begin
         bubble_cnt_d = '0;
      end else if (!out_valid && (bubble_cnt_q != CNT_MAX)) begin
         bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bubble_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed stimulus with a scoreboard queue; a negedge monitor pops and compares
// every beat that leaves the stage. Works with or without PIPE_SKID_EN.
module tb_pipe_stage_reg;
   localparam int unsigned       DATA_W     = 32;
   localparam int unsigned       CTRL_W     = 4;
   localparam int unsigned       CNT_W      = 8;
   localparam logic [CTRL_W-1:0] FLUSH_CTRL = 4'hA;
   localparam logic [CNT_W-1:0]  CNT_SAT    = 8'hFF;
`ifdef PIPE_SKID_EN
   localparam logic BP_RDY_FIRST = 1'b1;
`else
   localparam logic BP_RDY_FIRST = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic [CTRL_W-1:0] in_ctrl = '0;
   logic              stall = 1'b0;
   logic              flush = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic              cnt_clr = 1'b0;
   logic [CNT_W-1:0]  bubble_cnt;

   pipe_stage_reg #(
      .DATA_W    (DATA_W),
      .CTRL_W    (CTRL_W),
      .FLUSH_CTRL(FLUSH_CTRL),
      .CNT_W     (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .stall     (stall),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .cnt_clr   (cnt_clr),
      .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] d;
      logic [CTRL_W-1:0] c;
      int                acc;
      bit                lag;
   } beat_t;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   int    cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [CTRL_W-1:0] ctrl_of(input logic [DATA_W-1:0] d);
      return d[3:0] ^ 4'h3;
   endfunction

   // Offer one beat; push its expectation once the bench sees the stage will take it.
   task automatic send(input logic [DATA_W-1:0] d, input bit lag);
      int t = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_ctrl  = ctrl_of(d);
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_checks++;
         $display("FAIL send_timeout: beat 0x%0h not accepted within 50 cycles, required acceptance", d);
      end else begin
         exp_q.push_back('{d, ctrl_of(d), cyc + 1, lag});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      beat_t e;
      if (reset && out_valid && out_ready && !stall) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL spurious_beat: got data 0x%0h, required no beat", out_data);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", out_data, e.d);
            check("beat_ctrl", out_ctrl, e.c);
            if (e.lag) check("beat_latency", cyc, e.acc);
         end
      end
      if (reset && !out_valid) check("bubble_ctrl", out_ctrl, FLUSH_CTRL);
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation still running at 100us, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      // Reset held while upstream offers a beat
      in_valid = 1'b1;
      in_data  = 32'h99;
      in_ctrl  = 4'h5;
      repeat (4) begin
         @(negedge clk);
         check("rst_out_valid", out_valid, 1'b0);
         check("rst_out_ctrl", out_ctrl, FLUSH_CTRL);
         check("rst_out_data", out_data, 32'h0);
         check("rst_bubble_cnt", bubble_cnt, 8'h0);
      end
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // Stream 0x10..0x17 back to back
      for (int i = 0; i < 8; i++) send(32'h10 + i, 1'b1);

      // Stall holds 0xA5 while 0xB6 waits
      send(32'hA5, 1'b0);
      stall    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hB6;
      in_ctrl  = ctrl_of(32'hB6);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_out_data", out_data, 32'hA5);
         check("stall_out_valid", out_valid, 1'b1);
`ifndef PIPE_SKID_EN
         check("stall_in_ready", in_ready, 1'b0);
`endif
         if (in_valid && in_ready) exp_q.push_back('{32'hB6, ctrl_of(32'hB6), 0, 1'b0});
         @(posedge clk);
         #1;
         if (in_ready == 1'b0 && exp_q.size() > 1) in_valid = 1'b0;
      end
      stall = 1'b0;
      if (in_valid) begin
         send(32'hB6, 1'b1);
      end else begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("post_stall_data", out_data, 32'hB6);
      check("post_stall_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;

      // Flush overrides stall; coincident 0xD4 is discarded and 0xC3 is squashed
      send(32'hC3, 1'b0);
      stall    = 1'b1;
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hD4;
      in_ctrl  = ctrl_of(32'hD4);
      @(posedge clk);
      #1;
      exp_q.delete();
      stall    = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_out_valid", out_valid, 1'b0);
      check("flush_out_ctrl", out_ctrl, FLUSH_CTRL);
      check("flush_out_data", out_data, 32'h0);
      check("flush_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // Flush without stall: 0xE1 drains downstream, coincident 0xF2 never emerges
      send(32'hE1, 1'b0);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hF2;
      in_ctrl  = ctrl_of(32'hF2);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush2_out_valid", out_valid, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: out_ready low for two edges mid-stream
      fork
         begin
            for (int i = 0; i < 8; i++) send(32'h20 + i, 1'b0);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            check("bp_in_ready_first", in_ready, BP_RDY_FIRST);
            @(negedge clk);
            check("bp_in_ready_full", in_ready, 1'b0);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      #1;
      check("bp_drained", exp_q.size(), 0);

      // Bubble counter: count, saturate, clear
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      check("cnt_cleared", bubble_cnt, 8'd0);
      repeat (10) @(posedge clk);
      #1;
      check("cnt_ten", bubble_cnt, 8'd10);
      repeat ((1 << CNT_W) + 5) @(posedge clk);
      #1;
      check("cnt_saturated", bubble_cnt, CNT_SAT);
      out_ready = 1'b0;
      cnt_clr   = 1'b1;
      send(32'h77, 1'b0);
      cnt_clr = 1'b0;
      check("cnt_clr_wins", bubble_cnt, 8'd0);
      repeat (5) @(posedge clk);
      #1;
      check("cnt_hold_valid", bubble_cnt, 8'd0);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Reset asserted while a beat is held
      out_ready = 1'b0;
      send(32'h88, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_out_data", out_data, 32'h0);
      check("midrst_out_ctrl", out_ctrl, FLUSH_CTRL);
      check("midrst_bubble_cnt", bubble_cnt, 8'd0);
      exp_q.delete();
      @(negedge clk);
      reset     = 1'b1;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("final_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
